// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-address width
// and the forwarding select codes used by the hazard and forwarding units.
package pipe_pkg;

   localparam int REG_AW = 3;

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_MEM_WAIT   = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_EXM  = 2'b01,
      FWD_MWB  = 2'b10
   } fwd_sel_e;

   // Plain 3-bit match; R0 is deliberately not special-cased here.
   function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                    input logic              uses,
                                    input logic [REG_AW-1:0] rd);
      return uses & (src == rd);
   endfunction

endpackage

// File: rtl/hazard_controller_bubble_tracker.sv
// Four per-stage bubble flags (ID, EX, EX/MEM, MEM/WB); 1 marks a bubble.
// Freeze holds the front stages while MEM/WB drains to a bubble.
module bubble_tracker (
   input  logic clk_i,
   input  logic rst_i,
   input  logic freeze_i,
   input  logic hold_id_i,
   input  logic flush_id_i,
   input  logic flush_ex_i,
   output logic id_bub_o,
   output logic ex_bub_o,
   output logic exm_bub_o,
   output logic mwb_bub_o
);

   logic id_bub_q, ex_bub_q, exm_bub_q, mwb_bub_q;
   logic id_bub_d, ex_bub_d, exm_bub_d, mwb_bub_d;

   always_comb begin
      id_bub_d  = id_bub_q;
      ex_bub_d  = ex_bub_q;
      exm_bub_d = exm_bub_q;
      mwb_bub_d = mwb_bub_q;
      if (freeze_i) begin
         mwb_bub_d = 1'b1;
      end else begin
         id_bub_d  = flush_id_i ? 1'b1 : (hold_id_i ? id_bub_q : 1'b0);
         ex_bub_d  = flush_ex_i ? 1'b1 : id_bub_q;
         exm_bub_d = ex_bub_q;
         mwb_bub_d = exm_bub_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_bub_q  <= 1'b1;
         ex_bub_q  <= 1'b1;
         exm_bub_q <= 1'b1;
         mwb_bub_q <= 1'b1;
      end else begin
         id_bub_q  <= id_bub_d;
         ex_bub_q  <= ex_bub_d;
         exm_bub_q <= exm_bub_d;
         mwb_bub_q <= mwb_bub_d;
      end
   end

   assign id_bub_o  = id_bub_q;
   assign ex_bub_o  = ex_bub_q;
   assign exm_bub_o = exm_bub_q;
   assign mwb_bub_o = mwb_bub_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait states; sole source of stage enables and flushes.
module hazard_controller
   import pipe_pkg::*;
#(
   parameter int LOAD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ID_Reg_Rs,
   input  logic [REG_AW-1:0] ID_Reg_Rt,
   input  logic              ID_uses_Rs,
   input  logic              ID_uses_Rt,
   input  logic [REG_AW-1:0] EX_Reg_Rd,
   input  logic              EX_mem_read,
   input  logic              EX_branch_taken,
   input  logic              EXM_mem_access,
   input  logic              mem_ready,
   output logic              PC_write,
   output logic              IFID_write,
   output logic              IDEX_write,
   output logic              EXM_write,
   output logic              IFID_flush,
   output logic              IDEX_flush,
   output logic              EX_valid_in,
   output logic              EXM_valid_in,
   output logic              MWB_valid_in,
   output logic [1:0]        hz_state
);

   hz_state_e  state_q, state_d, eff_state;
   logic [2:0] stall_cnt_q, stall_cnt_d;
   logic       id_bub, ex_bub, exm_bub, mwb_bub;
   logic       freeze, hold_id, flush_id, flush_ex;
   logic       mem_wait, load_use, br;

   assign mem_wait = ~exm_bub & EXM_mem_access & ~mem_ready;
   assign br       = ~ex_bub & EX_branch_taken;
   assign load_use = ~id_bub & ~ex_bub & EX_mem_read &
                     (src_hit(ID_Reg_Rs, ID_uses_Rs, EX_Reg_Rd) |
                      src_hit(ID_Reg_Rt, ID_uses_Rt, EX_Reg_Rd));

   always_comb begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_write  = 1'b1;
      EXM_write   = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      freeze      = 1'b0;
      hold_id     = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      // Once memory is ready, MEM_WAIT behaves as the state it interrupted.
      eff_state   = state_q;
      if (state_q == HZ_MEM_WAIT)
         eff_state = (stall_cnt_q != 3'd0) ? HZ_LOAD_STALL : HZ_RUN;
      state_d     = eff_state;
      stall_cnt_d = stall_cnt_q;

      if (mem_wait) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_write = 1'b0;
         EXM_write  = 1'b0;
         freeze     = 1'b1;
         state_d    = HZ_MEM_WAIT;
      end else if (br) begin
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
         flush_id    = 1'b1;
         flush_ex    = 1'b1;
         stall_cnt_d = 3'd0;
         state_d     = HZ_RUN;
      end else if (load_use && eff_state == HZ_RUN) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_flush = 1'b1;
         hold_id    = 1'b1;
         flush_ex   = 1'b1;
         if (LOAD_LAT > 1) begin
            state_d     = HZ_LOAD_STALL;
            stall_cnt_d = 3'(LOAD_LAT - 1);
         end
      end else if (eff_state == HZ_LOAD_STALL) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_flush  = 1'b1;
         hold_id     = 1'b1;
         flush_ex    = 1'b1;
         stall_cnt_d = stall_cnt_q - 3'd1;
         state_d     = (stall_cnt_q == 3'd1) ? HZ_RUN : HZ_LOAD_STALL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HZ_RUN;
         stall_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   bubble_tracker u_bub (
      .clk_i      (clk),
      .rst_i      (rst),
      .freeze_i   (freeze),
      .hold_id_i  (hold_id),
      .flush_id_i (flush_id),
      .flush_ex_i (flush_ex),
      .id_bub_o   (id_bub),
      .ex_bub_o   (ex_bub),
      .exm_bub_o  (exm_bub),
      .mwb_bub_o  (mwb_bub)
   );

   assign EX_valid_in  = ex_bub;
   assign EXM_valid_in = exm_bub;
   assign MWB_valid_in = mwb_bub;
   assign hz_state     = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: LOAD_LAT=1 and LOAD_LAT=3 instances driven
// from one vector table, plus a hand-written asynchronous reset sequence.
module tb_hazard_controller;

   typedef struct packed {
      logic [2:0] rs;
      logic       urs;
      logic [2:0] rt;
      logic       urt;
      logic [2:0] rd;
      logic       ld;
      logic       br;
      logic       acc;
      logic       rdy;
   } in_t;

   typedef struct packed {
      logic [3:0] en;   // PC, IFID, IDEX, EXM write
      logic [1:0] fl;   // IFID, IDEX flush
      logic [2:0] bub;  // EX, EXM, MWB bubble flags
      logic [1:0] st;
   } out_t;

   typedef struct {
      int         dut;
      string      name;
      in_t        stim;
      out_t       exp;
      logic       chk_cnt;
      logic [2:0] cnt;
   } vec_t;

   logic clk, rst;
   in_t  in1, in3;
   logic pc1, ifw1, idw1, exw1, iff1, idf1, exv1, exmv1, mwbv1;
   logic pc3, ifw3, idw3, exw3, iff3, idf3, exv3, exmv3, mwbv3;
   logic [1:0] st1, st3;

   int   checks = 0;
   int   errors = 0;
   out_t exp_q[$];
   vec_t vecs[$];

   hazard_controller #(.LOAD_LAT(1)) u1 (
      .clk(clk), .rst(rst),
      .ID_Reg_Rs(in1.rs), .ID_Reg_Rt(in1.rt),
      .ID_uses_Rs(in1.urs), .ID_uses_Rt(in1.urt),
      .EX_Reg_Rd(in1.rd), .EX_mem_read(in1.ld),
      .EX_branch_taken(in1.br), .EXM_mem_access(in1.acc), .mem_ready(in1.rdy),
      .PC_write(pc1), .IFID_write(ifw1), .IDEX_write(idw1), .EXM_write(exw1),
      .IFID_flush(iff1), .IDEX_flush(idf1),
      .EX_valid_in(exv1), .EXM_valid_in(exmv1), .MWB_valid_in(mwbv1),
      .hz_state(st1)
   );

   hazard_controller #(.LOAD_LAT(3)) u3 (
      .clk(clk), .rst(rst),
      .ID_Reg_Rs(in3.rs), .ID_Reg_Rt(in3.rt),
      .ID_uses_Rs(in3.urs), .ID_uses_Rt(in3.urt),
      .EX_Reg_Rd(in3.rd), .EX_mem_read(in3.ld),
      .EX_branch_taken(in3.br), .EXM_mem_access(in3.acc), .mem_ready(in3.rdy),
      .PC_write(pc3), .IFID_write(ifw3), .IDEX_write(idw3), .EXM_write(exw3),
      .IFID_flush(iff3), .IDEX_flush(idf3),
      .EX_valid_in(exv3), .EXM_valid_in(exmv3), .MWB_valid_in(mwbv3),
      .hz_state(st3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk_in(input int rs, input bit urs, input int rt, input bit urt,
                                 input int rd, input bit ld, input bit br,
                                 input bit acc, input bit rdy);
      in_t v;
      v.rs = 3'(rs);  v.urs = urs;
      v.rt = 3'(rt);  v.urt = urt;
      v.rd = 3'(rd);  v.ld  = ld;
      v.br = br;      v.acc = acc;  v.rdy = rdy;
      return v;
   endfunction

   function automatic out_t mo(input logic [3:0] en, input logic [1:0] fl,
                               input logic [2:0] bub, input logic [1:0] st);
      out_t o;
      o.en = en; o.fl = fl; o.bub = bub; o.st = st;
      return o;
   endfunction

   function automatic out_t get_out(input int dut);
      if (dut == 1) return mo({pc1, ifw1, idw1, exw1}, {iff1, idf1}, {exv1, exmv1, mwbv1}, st1);
      return mo({pc3, ifw3, idw3, exw3}, {iff3, idf3}, {exv3, exmv3, mwbv3}, st3);
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got en=%b fl=%b bub=%b st=%0d, want en=%b fl=%b bub=%b st=%0d",
                  name, act.en, act.fl, act.bub, act.st, exp.en, exp.fl, exp.bub, exp.st);
      end
   endtask

   task automatic add(input int dut, input string name, input in_t stim, input out_t exp,
                      input logic chk_cnt = 1'b0, input logic [2:0] cnt = 3'd0);
      vec_t v;
      v.dut = dut; v.name = name; v.stim = stim; v.exp = exp;
      v.chk_cnt = chk_cnt; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   // Called just after a rising edge; compares at the falling edge.
   task automatic step(input vec_t v);
      if (v.dut == 1) begin in1 = v.stim; in3 = '0; end
      else            begin in3 = v.stim; in1 = '0; end
      exp_q.push_back(v.exp);
      @(negedge clk);
      check(v.name, get_out(v.dut), exp_q.pop_front());
      if (v.chk_cnt) begin
         checks++;
         if (u3.stall_cnt_q !== v.cnt) begin
            errors++;
            $display("FAIL %s_cnt: got stall_cnt=%0d, want %0d", v.name, u3.stall_cnt_q, v.cnt);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_t  IDLE, LU, BR_LU, WAIT, READY;
      out_t RST_OUT;
      vec_t v;
      IDLE    = '0;
      LU      = mk_in(3, 1, 0, 0, 3, 1, 0, 0, 0);
      BR_LU   = mk_in(3, 1, 0, 0, 3, 1, 1, 0, 0);
      WAIT    = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      READY   = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      RST_OUT = mo(4'b1111, 2'b00, 3'b111, 2'd0);

      // Empty pipeline filling
      add(1, "rst_state", IDLE, mo(4'b1111, 2'b00, 3'b111, 2'd0));
      add(1, "fill1",     IDLE, mo(4'b1111, 2'b00, 3'b111, 2'd0));
      add(1, "fill2",     IDLE, mo(4'b1111, 2'b00, 3'b011, 2'd0));
      add(1, "fill3",     IDLE, mo(4'b1111, 2'b00, 3'b001, 2'd0));
      add(1, "fill4",     IDLE, mo(4'b1111, 2'b00, 3'b000, 2'd0));
      // Load-use with LOAD_LAT=1, plus non-stalling near misses
      add(1, "lu1_stall", LU, mo(4'b0011, 2'b01, 3'b000, 2'd0));
      add(1, "lu1_exbub", LU, mo(4'b1111, 2'b00, 3'b100, 2'd0));
      add(1, "rs_unused", mk_in(3, 0, 5, 1, 3, 1, 0, 0, 0), mo(4'b1111, 2'b00, 3'b010, 2'd0));
      add(1, "rt_hit",    mk_in(0, 0, 3, 1, 3, 1, 0, 0, 0), mo(4'b0011, 2'b01, 3'b001, 2'd0));
      add(1, "rt_after",  IDLE, mo(4'b1111, 2'b00, 3'b100, 2'd0));
      add(1, "drain1",    IDLE, mo(4'b1111, 2'b00, 3'b010, 2'd0));
      add(1, "no_load",   mk_in(3, 1, 0, 0, 3, 0, 0, 0, 0), mo(4'b1111, 2'b00, 3'b001, 2'd0));
      add(1, "full1",     IDLE, mo(4'b1111, 2'b00, 3'b000, 2'd0));
      // Load-use with LOAD_LAT=3
      add(3, "lu3_hit",   LU,   mo(4'b0011, 2'b01, 3'b000, 2'd0));
      add(3, "lu3_s1",    LU,   mo(4'b0011, 2'b01, 3'b100, 2'd1));
      add(3, "lu3_s2",    LU,   mo(4'b0011, 2'b01, 3'b110, 2'd1));
      add(3, "lu3_done",  IDLE, mo(4'b1111, 2'b00, 3'b111, 2'd0));
      add(3, "lu3_d1",    IDLE, mo(4'b1111, 2'b00, 3'b011, 2'd0));
      add(3, "lu3_d2",    IDLE, mo(4'b1111, 2'b00, 3'b001, 2'd0));
      add(3, "lu3_d3",    IDLE, mo(4'b1111, 2'b00, 3'b000, 2'd0));
      // Branch beats a simultaneous load-use
      add(1, "br_lu",     BR_LU, mo(4'b1111, 2'b11, 3'b000, 2'd0));
      add(1, "br_stale",  BR_LU, mo(4'b1111, 2'b00, 3'b100, 2'd0));
      add(1, "br_d1",     IDLE,  mo(4'b1111, 2'b00, 3'b110, 2'd0));
      add(1, "br_d2",     IDLE,  mo(4'b1111, 2'b00, 3'b011, 2'd0));
      add(1, "br_d3",     IDLE,  mo(4'b1111, 2'b00, 3'b001, 2'd0));
      add(1, "br_d4",     IDLE,  mo(4'b1111, 2'b00, 3'b000, 2'd0));
      // Memory wait interrupting a LOAD_LAT=3 stall
      add(3, "mw_lu",     LU,    mo(4'b0011, 2'b01, 3'b000, 2'd0));
      add(3, "mw_w1",     WAIT,  mo(4'b0000, 2'b00, 3'b100, 2'd1));
      add(3, "mw_w2",     WAIT,  mo(4'b0000, 2'b00, 3'b101, 2'd2));
      add(3, "mw_w3",     WAIT,  mo(4'b0000, 2'b00, 3'b101, 2'd2));
      add(3, "mw_rdy",    READY, mo(4'b0011, 2'b01, 3'b101, 2'd2), 1'b1, 3'd2);
      add(3, "mw_ls",     IDLE,  mo(4'b0011, 2'b01, 3'b110, 2'd1), 1'b1, 3'd1);
      add(3, "mw_ign",    WAIT,  mo(4'b1111, 2'b00, 3'b111, 2'd0), 1'b1, 3'd0);
      add(3, "mw_ign2",   WAIT,  mo(4'b1111, 2'b00, 3'b011, 2'd0));
      add(3, "mw_d1",     IDLE,  mo(4'b1111, 2'b00, 3'b001, 2'd0));
      add(3, "mw_d2",     IDLE,  mo(4'b1111, 2'b00, 3'b000, 2'd0));
      // Memory wait from RUN returns to RUN
      add(1, "run_w1",    WAIT,  mo(4'b0000, 2'b00, 3'b000, 2'd0));
      add(1, "run_w2",    WAIT,  mo(4'b0000, 2'b00, 3'b001, 2'd2));
      add(1, "run_rdy",   READY, mo(4'b1111, 2'b00, 3'b001, 2'd2));
      add(1, "run_after", IDLE,  mo(4'b1111, 2'b00, 3'b000, 2'd0));
      add(1, "mw_enter",  WAIT,  mo(4'b0000, 2'b00, 3'b000, 2'd0));

      in1 = '0;
      in3 = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(RST_OUT);
      check("rst_held1", get_out(1), exp_q.pop_front());
      exp_q.push_back(RST_OUT);
      check("rst_held3", get_out(3), exp_q.pop_front());
      rst = 1'b0;

      foreach (vecs[i]) step(vecs[i]);

      // Asynchronous reset in the middle of a MEM_WAIT cycle
      in1 = WAIT;
      #1;
      exp_q.push_back(mo(4'b0000, 2'b00, 3'b001, 2'd2));
      check("mw_before_rst", get_out(1), exp_q.pop_front());
      #1;
      rst = 1'b1;
      #1;
      exp_q.push_back(RST_OUT);
      check("async_rst1", get_out(1), exp_q.pop_front());
      exp_q.push_back(RST_OUT);
      check("async_rst3", get_out(3), exp_q.pop_front());
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      v.dut = 1; v.name = "post_rst"; v.stim = IDLE;
      v.exp = mo(4'b1111, 2'b00, 3'b111, 2'd0);
      v.chk_cnt = 1'b0; v.cnt = 3'd0;
      step(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
